reaction_ctrl: RTL
==================

// Module: reaction_ctrl
// PURPOSE
//   Sequencer for the reaction-time counter. Runs an F1-style start sequence: lights ramp
//   on, pseudo-random hold, lights out, then the counter is enabled until the player presses.
//   Detects jump starts and timeouts, and drives the counter's enable and clear inputs.
//   Sits between the debounced KEY edge detectors / 1 ms tick generator and the counter.
// PARAMETERS
//   N_LIGHTS    10     number of start lights (ledr width), >=2
//   STEP_MS     500    ms between successive lights turning on
//   DELAY_MIN   250    minimum ms of the random hold after all lights are lit
//   DELAY_MASK  1023   AND-mask on the LFSR value added to DELAY_MIN (2^k-1)
//   TIMEOUT_MS  9999   ms in TIMING before a no-press timeout
// PORTS
//   clk          in   1         system clock
//   reset        in   1         synchronous, active-high; overrides all other inputs
//   tick_ms      in   1         single-cycle strobe, once per ms
//   start        in   1         single-cycle pulse, start button pressed
//   stop         in   1         single-cycle pulse, reaction button pressed
//   rt_in        in   16        current reaction_time from the counter
//   ledr         out  N_LIGHTS  start lights
//   count_en     out  1         enable to the counter
//   count_clr    out  1         clear to the counter, single-cycle pulse
//   time_valid   out  1         result valid (DONE, no timeout)
//   jump_start   out  1         foul flag (FOUL state)
//   timeout      out  1         no press within TIMEOUT_MS
//   best_time    out  16        best (minimum) valid time
//   best_valid   out  1         best_time holds a captured result
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; LFSR <= 16'hACE1; best_valid 0, best_time 0.
//   - States: IDLE, LIGHTS, HOLD, TIMING, DONE, FOUL. Outputs decode from registered state.
//   - IDLE/DONE/FOUL + start: -> LIGHTS; count_clr=1 for that one cycle; ledr<=0; flags cleared.
//   - LIGHTS: ms counter counts tick_ms; every STEP_MS ticks ledr<={ledr[N-2:0],1'b1}. When
//     STEP_MS ticks elapse with ledr all ones: -> HOLD, hold<=DELAY_MIN+(lfsr & DELAY_MASK).
//   - HOLD: ledr all ones; hold decrements on tick_ms; at tick with hold==1 -> TIMING.
//   - TIMING: ledr=0; count_en=1 in every cycle state==TIMING. stop -> DONE (count_en 0 from
//     the next cycle); time_valid=1 while in DONE. TIMEOUT_MS ticks without stop -> DONE
//     with timeout=1, time_valid=0.
//   - stop in LIGHTS or HOLD -> FOUL: jump_start=1, ledr all ones, count_en 0.
//   - stop in IDLE/DONE/FOUL ignored; start in LIGHTS/HOLD/TIMING ignored (no restart).
//   - Same-cycle start+stop: in TIMING stop wins; in LIGHTS/HOLD stop wins (FOUL);
//     in IDLE/DONE/FOUL start wins.
//   - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clk, never reaches zero.
//   - Counters saturate internally; the ms counter resets on every state change.
//   - Reset mid-sequence: next cycle IDLE, count_en 0, ledr 0; counter not cleared.
// CONFIGURATION
//   REACTION_BEST_EN defined: one cycle after entering DONE with timeout=0, if
//     best_valid==0 or rt_in<best_time, then best_time<=rt_in and best_valid<=1.
//     Counter value is stable by then. Cleared only by reset.
//   REACTION_BEST_EN undefined: best_time=0 and best_valid=0 constantly; ports remain.
// TESTING  (N_LIGHTS=4, STEP_MS=2, DELAY_MIN=3, DELAY_MASK=3, TIMEOUT_MS=20)
//   - start in IDLE -> count_clr 1 cycle; ledr 0001,0011,0111,1111 every 2 ticks; HOLD.
//   - hold with LFSR&3=2 -> TIMING after exactly 5 ticks; count_en=1, ledr=0.
//   - stop 7 ticks into TIMING -> DONE, count_en low next cycle, time_valid=1.
//   - stop during LIGHTS (ledr=0011) -> FOUL, jump_start=1, ledr=1111, count_en never high.
//   - no stop for 20 ticks in TIMING -> DONE, timeout=1, time_valid=0.
//   - BEST_EN: rt_in 300 then 250 then 400 -> best_time 300,250,250; reset mid-HOLD -> IDLE.

Source files
------------

// File: rtl/reaction_ctrl.sv
// Start-sequence controller for the reaction-time game: light ramp, random hold, timing,
// jump-start and timeout detection. Optional best-time capture under REACTION_BEST_EN.
module reaction_ctrl #(
    parameter int unsigned N_LIGHTS   = 10,
    parameter int unsigned STEP_MS    = 500,
    parameter int unsigned DELAY_MIN  = 250,
    parameter int unsigned DELAY_MASK = 1023,
    parameter int unsigned TIMEOUT_MS = 9999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_ms,
    input  logic                start,
    input  logic                stop,
    input  logic [15:0]         rt_in,
    output logic [N_LIGHTS-1:0] ledr,
    output logic                count_en,
    output logic                count_clr,
    output logic                time_valid,
    output logic                jump_start,
    output logic                timeout,
    output logic [15:0]         best_time,
    output logic                best_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StLights,
        StHold,
        StTiming,
        StDone,
        StFoul
    } state_e;

    localparam logic [15:0] StepLast    = 16'(STEP_MS - 1);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_MS - 1);
    localparam logic [15:0] HoldMin     = 16'(DELAY_MIN);
    localparam logic [15:0] HoldMask    = 16'(DELAY_MASK);

    state_e              r_state;
    state_e              w_next;
    logic [15:0]         r_ms;
    logic [15:0]         r_hold;
    logic [15:0]         r_lfsr;
    logic [N_LIGHTS-1:0] r_ledr;
    logic                r_count_clr;
    logic                r_timeout;

    logic w_step;
    logic w_all_on;
    logic w_restart;
    logic w_lfsr_fb;

    assign w_step    = tick_ms && (r_ms == StepLast);
    assign w_all_on  = &r_ledr;
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_restart = (w_next == StLights) && (r_state != StLights);

    // stop takes priority over start and ticks everywhere it is meaningful
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle, StDone, StFoul: begin
                if (start) w_next = StLights;
            end
            StLights: begin
                if (stop)                     w_next = StFoul;
                else if (w_step && w_all_on)  w_next = StHold;
            end
            StHold: begin
                if (stop)                              w_next = StFoul;
                else if (tick_ms && r_hold <= 16'd1)   w_next = StTiming;
            end
            StTiming: begin
                if (stop)                                   w_next = StDone;
                else if (tick_ms && r_ms == TimeoutLast)    w_next = StDone;
            end
            default: w_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_ms        <= '0;
            r_hold      <= '0;
            r_lfsr      <= 16'hACE1;
            r_ledr      <= '0;
            r_count_clr <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
            r_count_clr <= w_restart;

            if (w_next != r_state) begin
                r_ms <= '0;
            end else if (r_state == StLights && w_step) begin
                r_ms <= '0;
            end else if (tick_ms && r_ms != 16'hFFFF) begin
                r_ms <= r_ms + 16'd1;
            end

            if (w_restart) begin
                r_ledr <= '0;
            end else if (r_state == StLights && w_step && !w_all_on) begin
                r_ledr <= {r_ledr[N_LIGHTS-2:0], 1'b1};
            end

            if (r_state == StLights && w_next == StHold) begin
                r_hold <= HoldMin + (r_lfsr & HoldMask);
            end else if (r_state == StHold && tick_ms && r_hold != 16'd0) begin
                r_hold <= r_hold - 16'd1;
            end

            if (w_restart) begin
                r_timeout <= 1'b0;
            end else if (r_state == StTiming && w_next == StDone && !stop) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        ledr = '0;
        unique case (r_state)
            StLights:       ledr = r_ledr;
            StHold, StFoul: ledr = '1;
            default:        ledr = '0;
        endcase
    end

    assign count_en   = (r_state == StTiming);
    assign count_clr  = r_count_clr;
    assign time_valid = (r_state == StDone) && !r_timeout;
    assign jump_start = (r_state == StFoul);
    assign timeout    = r_timeout;

`ifdef REACTION_BEST_EN
    logic        r_was_timing;
    logic [15:0] r_best_time;
    logic        r_best_valid;

    // Capture one cycle into DONE so the counter has settled on its final value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_was_timing <= 1'b0;
            r_best_time  <= '0;
            r_best_valid <= 1'b0;
        end else begin
            r_was_timing <= (r_state == StTiming);
            if (r_state == StDone && r_was_timing && !r_timeout &&
                (!r_best_valid || rt_in < r_best_time)) begin
                r_best_time  <= rt_in;
                r_best_valid <= 1'b1;
            end
        end
    end

    assign best_time  = r_best_time;
    assign best_valid = r_best_valid;
`else
    logic w_unused_rt;
    assign w_unused_rt = ^rt_in;
    assign best_time   = '0;
    assign best_valid  = 1'b0;
`endif

endmodule
